// File: rtl/dff_frame_deser.sv
// Serial frame receiver: hunts for a sync pattern, shifts in an MSB-first payload,
// optionally checks even parity and presents the word on a valid/ready port.
module dff_frame_deser #(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = 4'b1011,
  parameter bit                PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_par_err,
  output logic              o_ovf,
  output logic              o_busy
);

  localparam int FILL_W = $clog2(SYNC_W + 1);
  localparam int CNT_W  = $clog2(DATA_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {HUNT, DATA, PAR} state_e;

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   hist_q, hist_d, histShift;
  logic [FILL_W-1:0]   fill_q, fill_d, fillInc;
  logic [CNT_W-1:0]    bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                parErr_q, parErr_d;
  logic                ovf_q, ovf_d;
  logic                frameDone;
  logic                frameParErr;
  logic [DATA_W-1:0]   frameData;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      hist_q   <= '0;
      fill_q   <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      parErr_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      parErr_q <= parErr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Fill count guards against matching on the zeros left in history after a restart.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    frameDone   = 1'b0;
    frameData   = shift_q;
    frameParErr = 1'b0;
    histShift   = {hist_q[SYNC_W-2:0], i_din};
    fillInc     = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;

    if (i_en) begin
      case (state_q)
        HUNT: begin
          hist_d = histShift;
          fill_d = fillInc;
          if (fillInc == FILL_MAX && histShift == SYNC_PAT) begin
            state_d  = DATA;
            bitCnt_d = '0;
          end
        end
        DATA: begin
          shift_d  = {shift_q[DATA_W-2:0], i_din};
          bitCnt_d = bitCnt_q + 1'b1;
          if (bitCnt_q == CNT_LAST) begin
            bitCnt_d = '0;
            if (PARITY_EN) begin
              state_d = PAR;
            end else begin
              frameDone = 1'b1;
              frameData = {shift_q[DATA_W-2:0], i_din};
            end
          end
        end
        PAR: begin
          frameDone   = 1'b1;
          frameParErr = ^{shift_q, i_din};
        end
        default: state_d = HUNT;
      endcase
    end

    if (frameDone) begin
      state_d = HUNT;
      hist_d  = '0;
      fill_d  = '0;
    end
  end

  // A completed frame may reuse the output register on the same edge it is drained.
  always_comb begin
    data_d   = data_q;
    parErr_d = parErr_q;
    valid_d  = valid_q;
    ovf_d    = 1'b0;
    if (frameDone) begin
      if (!valid_q || i_ready) begin
        data_d   = frameData;
        parErr_d = frameParErr;
        valid_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    o_data    = data_q;
    o_valid   = valid_q;
    o_par_err = parErr_q;
    o_ovf     = ovf_q;
    o_busy    = (state_q == DATA) || (state_q == PAR);
  end

endmodule

// File: tb/tb_dff_frame_deser.sv
// Testbench for dff_frame_deser: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_dff_frame_deser;

  localparam int         DW  = 8;
  localparam int         SW  = 4;
  localparam logic [3:0] PAT = 4'b1011;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       din;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       parErr;
  logic       ovf;
  logic       busy;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    bit         en;
    bit         din;
    bit         ready;
    bit         expValid;
    logic [7:0] expData;
    bit         expParErr;
    bit         expOvf;
    bit         expBusy;
  } vec_t;

  vec_t        vecs[13];
  logic [12:0] stream;

  bit         synced;
  bit         huntQ[$];
  bit         payQ[$];
  bit         mValid;
  bit         mParErr;
  bit         mOvf;
  bit         mBusy;
  logic [7:0] mData;

  dff_frame_deser #(
    .DATA_W(DW), .SYNC_W(SW), .SYNC_PAT(PAT), .PARITY_EN(1'b1)
  ) dut (
    .clk(clk), .i_rst(rst), .i_en(en), .i_din(din), .i_ready(ready),
    .o_data(data), .o_valid(valid), .o_par_err(parErr), .o_ovf(ovf), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    synced = 1'b0;
    huntQ.delete();
    payQ.delete();
    mValid = 1'b0; mData = 8'h00; mParErr = 1'b0; mOvf = 1'b0; mBusy = 1'b0;
  endtask

  // Frame rules: sync = last SW bits since restart equal PAT; then DW payload bits + parity.
  task automatic modelBit(input bit b, output bit done, output logic [7:0] fd, output bit fp);
    logic [3:0] w;
    int ones;
    done = 1'b0; fd = 8'h00; fp = 1'b0; w = 4'h0; ones = 0;
    if (!synced) begin
      huntQ.push_back(b);
      if (huntQ.size() >= SW) begin
        for (int k = 0; k < SW; k++) w = {w[2:0], huntQ[huntQ.size() - SW + k]};
        if (w == PAT) begin
          synced = 1'b1;
          huntQ.delete();
        end
      end
    end else begin
      payQ.push_back(b);
      if (payQ.size() == DW + 1) begin
        for (int k = 0; k < DW; k++) fd = {fd[6:0], payQ[k]};
        for (int k = 0; k <= DW; k++) ones += int'(payQ[k]);
        fp = (ones % 2) != 0;
        done = 1'b1;
        synced = 1'b0;
        payQ.delete();
      end
    end
  endtask

  task automatic modelEdge(input bit e, input bit d, input bit r);
    bit done;
    logic [7:0] fd;
    bit fp;
    done = 1'b0; fd = 8'h00; fp = 1'b0;
    if (e) modelBit(d, done, fd, fp);
    if (done) begin
      if (!mValid || r) begin
        mData = fd; mParErr = fp; mValid = 1'b1; mOvf = 1'b0;
      end else begin
        mOvf = 1'b1;
      end
    end else begin
      mOvf = 1'b0;
      if (mValid && r) mValid = 1'b0;
    end
    mBusy = synced;
  endtask

  task automatic applyStimulus(input bit e, input bit d, input bit r);
    @(negedge clk);
    en = e; din = d; ready = r;
    @(posedge clk);
    modelEdge(e, d, r);
    #1;
  endtask

  task automatic checkBit(input string name, input string field, input logic act, input logic exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s.%s got %b expected %b", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input bit ev, input logic [7:0] ed,
                             input bit ep, input bit eo, input bit eb);
    checkBit(name, "valid", valid, ev);
    checkBit(name, "parErr", parErr, ep);
    checkBit(name, "ovf", ovf, eo);
    checkBit(name, "busy", busy, eb);
    nTests++;
    if (data !== ed) begin
      nFail++;
      $display("[TB] FAIL %s.data got %h expected %h", name, data, ed);
    end
  endtask

  task automatic stepChk(input bit e, input bit d, input bit r, input string name);
    applyStimulus(e, d, r);
    checkOutput(name, mValid, mData, mParErr, mOvf, mBusy);
  endtask

  task automatic sendSync(input bit r, input string name);
    for (int k = SW - 1; k >= 0; k--) stepChk(1'b1, PAT[k], r, name);
  endtask

  task automatic sendDataBits(input logic [7:0] d, input bit r, input string name);
    for (int k = DW - 1; k >= 0; k--) stepChk(1'b1, d[k], r, name);
  endtask

  task automatic sendFrame(input logic [7:0] d, input bit par, input bit r, input string name);
    sendSync(r, name);
    sendDataBits(d, r, name);
    stepChk(1'b1, par, r, name);
  endtask

  task automatic hardReset();
    rst = 1'b1; en = 1'b0; ready = 1'b0;
    #1;
    modelReset();
  endtask

  initial begin
    bit gapBits[5];
    din = 1'b0;
    hardReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Frame 0x3C, parity 0, downstream always ready.
    stream = 13'b1011_0011_1100_0;
    for (int i = 0; i < 13; i++) begin
      vecs[i] = '{en: 1'b1, din: stream[12 - i], ready: 1'b1,
                  expValid: (i == 12), expData: (i == 12) ? 8'h3C : 8'h00,
                  expParErr: 1'b0, expOvf: 1'b0, expBusy: (i >= 3 && i < 12)};
    end
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].en, vecs[i].din, vecs[i].ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData,
                  vecs[i].expParErr, vecs[i].expOvf, vecs[i].expBusy);
    end
    stepChk(1'b0, 1'b0, 1'b1, "drain1");

    sendFrame(8'h3C, 1'b1, 1'b1, "par1");
    checkOutput("par1End", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    stepChk(1'b0, 1'b0, 1'b1, "drain2");

    // Second frame completes while the first is still pending.
    sendFrame(8'h3C, 1'b0, 1'b0, "ovfA");
    sendFrame(8'h81, 1'b0, 1'b0, "ovfB");
    checkOutput("ovfPulse", 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    stepChk(1'b0, 1'b0, 1'b0, "ovfHold");
    checkOutput("ovfGone", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    stepChk(1'b0, 1'b0, 1'b1, "xfer");
    checkOutput("xferDone", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

    // Drain and reload on the same edge.
    sendFrame(8'h3C, 1'b0, 1'b0, "simA");
    sendSync(1'b0, "simB");
    sendDataBits(8'h81, 1'b0, "simB");
    stepChk(1'b1, 1'b0, 1'b1, "simPar");
    checkOutput("simEnd", 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    stepChk(1'b0, 1'b0, 1'b1, "drain3");

    // Asynchronous reset part-way through a payload.
    sendFrame(8'h3C, 1'b0, 1'b0, "rstA");
    sendSync(1'b0, "rstB");
    stepChk(1'b1, 1'b1, 1'b0, "rstB");
    stepChk(1'b1, 1'b0, 1'b0, "rstB");
    stepChk(1'b1, 1'b1, 1'b0, "rstB");
    #2;
    hardReset();
    checkOutput("asyncRst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    sendFrame(8'hA5, 1'b0, 1'b1, "a5");
    checkOutput("a5End", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    stepChk(1'b0, 1'b0, 1'b1, "drain4");

    // Sync bits separated by disabled cycles carrying junk.
    gapBits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      stepChk(1'b1, gapBits[i], 1'b1, "gapBit");
      if (i == 3) checkOutput("preSync", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
      if (i < 4) begin
        stepChk(1'b0, 1'($urandom), 1'b1, "gapJunk");
        stepChk(1'b0, 1'($urandom), 1'b1, "gapJunk");
      end
    end
    checkOutput("postSync", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    sendDataBits(8'hFF, 1'b1, "ff");
    stepChk(1'b1, 1'b0, 1'b1, "ffPar");
    checkOutput("ffEnd", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);

    repeat (3000) stepChk($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), "rand");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
